// File: rtl/matrix_pkg.sv
// Shared definitions for the sequential matrix add/subtract block: op encoding, FSM states
// and the constant helpers used to size the chunk counter.
package matrix_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
      return (n + d - 1) / d;
   endfunction

   // Never returns 0 so a one-chunk configuration still gets a 1-bit counter.
   function automatic int unsigned clog2_min1(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r = r + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/matrix_lane_alu.sv
// One signed add/subtract lane with overflow detection. MATRIX_SUM_SATURATE_EN selects
// clamping of overflowing results; otherwise the result wraps modulo 2^DATA_WIDTH.
module matrix_lane_alu
   import matrix_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  op_i,
   input  logic                  enable_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  overflow_o
);

   logic [DATA_WIDTH:0] a_ext;
   logic [DATA_WIDTH:0] b_ext;
   logic [DATA_WIDTH:0] full;
   logic                ovf_raw;

   always_comb begin
      a_ext   = {a_i[DATA_WIDTH-1], a_i};
      b_ext   = {b_i[DATA_WIDTH-1], b_i};
      full    = (op_i == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
      // The W+1-bit result fits in W bits only when its top two bits agree.
      ovf_raw = full[DATA_WIDTH] ^ full[DATA_WIDTH-1];
`ifdef MATRIX_SUM_SATURATE_EN
      if (ovf_raw) begin
         result_o = full[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
         result_o = full[DATA_WIDTH-1:0];
      end
`else
      result_o = full[DATA_WIDTH-1:0];
`endif
      overflow_o = ovf_raw & enable_i;
   end

endmodule

// File: rtl/matrix_addsub_seq.sv
// Sequential C = A +/- B over an MxN signed matrix, LANES elements per clock.
// MATRIX_SUM_SATURATE_EN (in matrix_lane_alu) switches lanes from wrapping to clamping.
module matrix_addsub_seq
   import matrix_pkg::*;
#(
   parameter int unsigned MATRIX_SIZE_M = 4,
   parameter int unsigned MATRIX_SIZE_N = 3,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned LANES         = 4
) (
   input  logic                                              i_clk,
   input  logic                                              i_rst,
   input  logic                                              i_start,
   input  logic                                              i_op,
   input  logic [MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] i_matrix_a,
   input  logic [MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] i_matrix_b,
   output logic [MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] o_matrix,
   output logic                                              o_ready,
   output logic                                              o_done,
   output logic                                              o_overflow
);

   localparam int unsigned ELEMS      = MATRIX_SIZE_M * MATRIX_SIZE_N;
   localparam int unsigned SIZE_BLOCK = ELEMS * DATA_WIDTH;
   localparam int unsigned CHUNKS     = ceil_div(ELEMS, LANES);
   localparam int unsigned CNT_W      = clog2_min1(CHUNKS);
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHUNKS - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SIZE_BLOCK-1:0]   a_q, a_d;
   logic [SIZE_BLOCK-1:0]   b_q, b_d;
   logic                    op_q, op_d;
   logic [SIZE_BLOCK-1:0]   res_q, res_d;
   logic                    ovf_q, ovf_d;

   int unsigned             lane_idx [LANES];
   logic                    lane_en  [LANES];
   logic [DATA_WIDTH-1:0]   lane_a   [LANES];
   logic [DATA_WIDTH-1:0]   lane_b   [LANES];
   logic [DATA_WIDTH-1:0]   lane_res [LANES];
   logic                    lane_ovf [LANES];

   // Operand steering: lanes past the last element stay disabled and see zeros.
   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_idx[l] = 32'(cnt_q) * LANES + l;
         lane_en[l]  = (state_q == StCalc) && (lane_idx[l] < ELEMS);
         lane_a[l]   = '0;
         lane_b[l]   = '0;
         if (lane_idx[l] < ELEMS) begin
            lane_a[l] = a_q[lane_idx[l]*DATA_WIDTH +: DATA_WIDTH];
            lane_b[l] = b_q[lane_idx[l]*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      matrix_lane_alu #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_alu (
         .a_i        (lane_a[l]),
         .b_i        (lane_b[l]),
         .op_i       (op_q),
         .enable_i   (lane_en[l]),
         .result_o   (lane_res[l]),
         .overflow_o (lane_ovf[l])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      o_ready = 1'b0;
      o_done  = 1'b0;

      unique case (state_q)
         StIdle: begin
            o_ready = 1'b1;
            if (i_start) begin
               a_d     = i_matrix_a;
               b_d     = i_matrix_b;
               op_d    = i_op;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            for (int unsigned l = 0; l < LANES; l++) begin
               if (lane_en[l]) begin
                  res_d[lane_idx[l]*DATA_WIDTH +: DATA_WIDTH] = lane_res[l];
                  ovf_d = ovf_d | lane_ovf[l];
               end
            end
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            o_done  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_matrix   = res_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Bench for matrix_addsub_seq: a LANES=4 and a LANES=5 instance share stimulus and are both
// checked against an element-wise arithmetic model.
module tb_matrix_addsub_seq;

   localparam int M  = 4;
   localparam int N  = 3;
   localparam int W  = 16;
   localparam int E  = M * N;
   localparam int SB = E * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          op;
   logic [SB-1:0] a;
   logic [SB-1:0] b;
   logic [SB-1:0] mat4, mat5;
   logic          rdy4, rdy5, done4, done5, ovf4, ovf5;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   matrix_addsub_seq #(
      .MATRIX_SIZE_M (M), .MATRIX_SIZE_N (N), .DATA_WIDTH (W), .LANES (4)
   ) dut4 (
      .i_clk (clk), .i_rst (rst), .i_start (start), .i_op (op),
      .i_matrix_a (a), .i_matrix_b (b), .o_matrix (mat4),
      .o_ready (rdy4), .o_done (done4), .o_overflow (ovf4)
   );

   matrix_addsub_seq #(
      .MATRIX_SIZE_M (M), .MATRIX_SIZE_N (N), .DATA_WIDTH (W), .LANES (5)
   ) dut5 (
      .i_clk (clk), .i_rst (rst), .i_start (start), .i_op (op),
      .i_matrix_a (a), .i_matrix_b (b), .o_matrix (mat5),
      .o_ready (rdy5), .o_done (done5), .o_overflow (ovf5)
   );

   // Element-wise reference: exact integer result, then wrap or clamp.
   function automatic void model(input logic [SB-1:0] ma, input logic [SB-1:0] mb,
                                 input logic mop, output logic [SB-1:0] r, output logic ov);
      r  = '0;
      ov = 1'b0;
      for (int i = 0; i < E; i++) begin
         int x, y, s;
         x = int'($signed(ma[i*W +: W]));
         y = int'($signed(mb[i*W +: W]));
         s = mop ? (x - y) : (x + y);
         if (s > 32767 || s < -32768) begin
            ov = 1'b1;
`ifdef MATRIX_SUM_SATURATE_EN
            s = (s > 32767) ? 32767 : -32768;
`endif
         end
         r[i*W +: W] = s[15:0];
      end
   endfunction

   // Drives one start and watches 10 cycles; done latency is in cycles after the accept edge.
   task automatic launch(input logic [SB-1:0] ta, input logic [SB-1:0] tb_v, input logic top,
                         input int glitch_k, output logic rdy_t0,
                         output int first4, output int first5, output int n4, output int n5);
      a = ta; b = tb_v; op = top; start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      rdy_t0 = rdy4 | rdy5;
      first4 = -1; first5 = -1; n4 = 0; n5 = 0;
      for (int k = 1; k <= 10; k++) begin
         if (k == glitch_k) begin
            start = 1'b1;
            a     = ~ta;
            b     = {SB{1'b1}} ^ tb_v;
            op    = ~top;
         end else if (k == glitch_k + 1) begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done4) begin n4++; if (first4 < 0) first4 = k; end
         if (done5) begin n5++; if (first5 < 0) first5 = k; end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (mat4 !== '0 || mat5 !== '0) begin
         errors++; $display("FAIL reset_matrix got %h / %h want 0", mat4, mat5);
      end
      checks++;
      if ({rdy4, rdy5, done4, done5, ovf4, ovf5} !== 6'b110000) begin
         errors++;
         $display("FAIL reset_flags got rdy/done/ovf=%b want 110000",
                  {rdy4, rdy5, done4, done5, ovf4, ovf5});
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_basic();
      logic [SB-1:0] ta, tb_v, er;
      logic          eo, r0;
      int            f4, f5, n4, n5;
      for (int i = 0; i < E; i++) begin
         ta[i*W +: W]   = 16'(i);
         tb_v[i*W +: W] = 16'(10 * i);
         er[i*W +: W]   = 16'(11 * i);
      end
      eo = 1'b0;
      launch(ta, tb_v, 1'b0, 0, r0, f4, f5, n4, n5);
      checks++;
      if (r0 !== 1'b0) begin errors++; $display("FAIL add_ready_fall got %b want 0", r0); end
      checks++;
      if (f4 != 3 || f5 != 3) begin
         errors++; $display("FAIL add_latency got %0d/%0d want 3", f4, f5);
      end
      checks++;
      if (n4 != 1 || n5 != 1) begin
         errors++; $display("FAIL add_done_count got %0d/%0d want 1", n4, n5);
      end
      checks++;
      if (mat4 !== er || mat5 !== er) begin
         errors++; $display("FAIL add_result got %h / %h want %h", mat4, mat5, er);
      end
      checks++;
      if (ovf4 !== eo || ovf5 !== eo) begin
         errors++; $display("FAIL add_ovf got %b/%b want %b", ovf4, ovf5, eo);
      end
   endtask

   task automatic test_sub();
      logic [SB-1:0] ta, tb_v;
      logic          r0;
      int            f4, f5, n4, n5;
      for (int i = 0; i < E; i++) begin
         ta[i*W +: W]   = 16'd5;
         tb_v[i*W +: W] = 16'd7;
      end
      launch(ta, tb_v, 1'b1, 0, r0, f4, f5, n4, n5);
      checks++;
      if (mat4 !== {E{16'hFFFE}} || mat5 !== {E{16'hFFFE}}) begin
         errors++; $display("FAIL sub_result got %h / %h want all fffe", mat4, mat5);
      end
      checks++;
      if (ovf4 !== 1'b0 || ovf5 !== 1'b0) begin
         errors++; $display("FAIL sub_ovf got %b/%b want 0", ovf4, ovf5);
      end
   endtask

   task automatic test_overflow();
      logic [SB-1:0] ta, tb_v;
      logic [15:0]   e0;
      logic          r0;
      int            f4, f5, n4, n5;
      ta = '0; tb_v = '0;
      ta[15:0]   = 16'h7FFF;
      tb_v[15:0] = 16'h0001;
`ifdef MATRIX_SUM_SATURATE_EN
      e0 = 16'h7FFF;
`else
      e0 = 16'h8000;
`endif
      launch(ta, tb_v, 1'b0, 0, r0, f4, f5, n4, n5);
      checks++;
      if (ovf4 !== 1'b1 || ovf5 !== 1'b1) begin
         errors++; $display("FAIL ovf_set got %b/%b want 1", ovf4, ovf5);
      end
      checks++;
      if (mat4[15:0] !== e0 || mat5[15:0] !== e0) begin
         errors++; $display("FAIL ovf_elem0 got %h/%h want %h", mat4[15:0], mat5[15:0], e0);
      end
      checks++;
      if (mat4[SB-1:16] !== '0 || mat5[SB-1:16] !== '0) begin
         errors++; $display("FAIL ovf_others got %h / %h want 0", mat4, mat5);
      end
      ta = '0; tb_v = '0;
      ta[W +: W] = 16'd3;
      launch(ta, tb_v, 1'b0, 0, r0, f4, f5, n4, n5);
      checks++;
      if (ovf4 !== 1'b0 || ovf5 !== 1'b0) begin
         errors++; $display("FAIL ovf_clear got %b/%b want 0", ovf4, ovf5);
      end
   endtask

   task automatic test_random();
      logic [SB-1:0] ta, tb_v, er;
      logic          eo, top, r0;
      int            f4, f5, n4, n5;
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < E; i++) begin
            ta[i*W +: W]   = 16'($urandom);
            tb_v[i*W +: W] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) tb_v[i*W +: W] = 16'($urandom_range(0, 8));
         end
         top = 1'($urandom);
         model(ta, tb_v, top, er, eo);
         launch(ta, tb_v, top, 0, r0, f4, f5, n4, n5);
         checks++;
         if (mat4 !== er || mat5 !== er) begin
            errors++; $display("FAIL rand%0d_result got %h / %h want %h", t, mat4, mat5, er);
         end
         checks++;
         if (ovf4 !== eo || ovf5 !== eo || f4 != 3 || f5 != 3) begin
            errors++;
            $display("FAIL rand%0d_ovf_lat got ovf %b/%b lat %0d/%0d want ovf %b lat 3",
                     t, ovf4, ovf5, f4, f5, eo);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [SB-1:0] ta, tb_v, er;
      logic          eo, r0;
      int            f4, f5, n4, n5;
      for (int i = 0; i < E; i++) begin
         ta[i*W +: W]   = 16'($urandom);
         tb_v[i*W +: W] = 16'($urandom_range(0, 1000));
      end
      model(ta, tb_v, 1'b0, er, eo);
      launch(ta, tb_v, 1'b0, 1, r0, f4, f5, n4, n5);
      checks++;
      if (mat4 !== er || mat5 !== er) begin
         errors++; $display("FAIL b2b_result got %h / %h want %h", mat4, mat5, er);
      end
      checks++;
      if (f4 != 3 || f5 != 3 || n4 != 1 || n5 != 1) begin
         errors++;
         $display("FAIL b2b_timing got lat %0d/%0d pulses %0d/%0d want 3 and 1", f4, f5, n4, n5);
      end
      checks++;
      if (ovf4 !== eo || ovf5 !== eo) begin
         errors++; $display("FAIL b2b_ovf got %b/%b want %b", ovf4, ovf5, eo);
      end
   endtask

   task automatic test_mid_reset();
      logic [SB-1:0] ta, tb_v, er;
      logic          eo, r0;
      int            f4, f5, n4, n5, nd;
      for (int i = 0; i < E; i++) begin
         ta[i*W +: W]   = 16'($urandom);
         tb_v[i*W +: W] = 16'($urandom);
      end
      a = ta; b = tb_v; op = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (mat4 !== '0 || mat5 !== '0 || rdy4 !== 1'b1 || rdy5 !== 1'b1) begin
         errors++;
         $display("FAIL midrst_state got %h / %h rdy %b%b want 0 and rdy 11", mat4, mat5,
                  rdy4, rdy5);
      end
      nd = 0;
      for (int k = 0; k < 8; k++) begin
         if (done4 || done5) nd++;
         @(posedge clk); #1;
      end
      checks++;
      if (nd != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", nd); end
      model(ta, tb_v, 1'b1, er, eo);
      launch(ta, tb_v, 1'b1, 0, r0, f4, f5, n4, n5);
      checks++;
      if (mat4 !== er || mat5 !== er || f4 != 3 || f5 != 3 || ovf4 !== eo || ovf5 !== eo) begin
         errors++;
         $display("FAIL midrst_fresh got %h / %h lat %0d/%0d ovf %b%b want %h lat 3 ovf %b",
                  mat4, mat5, f4, f5, ovf4, ovf5, er, eo);
      end
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_sub();
      test_overflow();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
